pll_reset_sequencer: RTL and testbench



---
 rtl/pll_reset_sequencer.sv | 168 ++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
// Qualifies the raw PLL lock signal and produces a clean synchronous reset,
// a ready flag and a saturating lock-loss counter for the PLL output domain.
// Reset release happens only after lock has been stable for STABLE_CYCLES and
// a further HOLD_CYCLES of held reset. Sustained lock loss or a software
// request puts the domain back into reset.
module pll_reset_sequencer #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1024,
  parameter int HOLD_CYCLES   = 16,
  parameter int LOSS_FILTER   = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pll_locked,
  input  logic             sw_rst,
  output logic             rst_out,
  output logic             ready,
  output logic [CNT_W-1:0] loss_count,
  output logic [1:0]       state_dbg
);

  // Counter widths: each counter only has to reach its limit minus one.
  localparam int STW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int HLW = (HOLD_CYCLES   > 1) ? $clog2(HOLD_CYCLES)   : 1;
  localparam int FLW = (LOSS_FILTER   > 1) ? $clog2(LOSS_FILTER)   : 1;

  localparam logic [STW-1:0] STABLE_LAST = STW'(STABLE_CYCLES - 1);
  localparam logic [HLW-1:0] HOLD_LAST   = HLW'(HOLD_CYCLES - 1);
  localparam logic [FLW-1:0] FILT_LAST   = FLW'(LOSS_FILTER - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  // Saturating increment for the lock-loss counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end
    return v + CNT_W'(1);
  endfunction

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;

  state_t           state;
  state_t           state_nxt;
  logic [STW-1:0]   stable_cnt;
  logic [STW-1:0]   stable_nxt;
  logic [HLW-1:0]   hold_cnt;
  logic [HLW-1:0]   hold_nxt;
  logic [FLW-1:0]   filt_cnt;
  logic [FLW-1:0]   filt_nxt;
  logic [FLW-1:0]   filt_step;
  logic             filt_expire;
  logic [CNT_W-1:0] loss_nxt;
  logic             rst_nxt;
  logic             ready_nxt;

  // Synchroniser: shift raw lock through SYNC_STAGES flops, no filtering.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  // Loss filter: expiry on the LOSS_FILTER-th consecutive low sample.
  assign filt_expire = !lock_s && (filt_cnt == FILT_LAST);
  assign filt_step   = lock_s ? '0 : (filt_cnt + FLW'(1));

  // State register plus its counters and the lock-loss count.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= WAIT_LOCK;
      stable_cnt <= '0;
      hold_cnt   <= '0;
      filt_cnt   <= '0;
      loss_count <= '0;
    end else begin
      state      <= state_nxt;
      stable_cnt <= stable_nxt;
      hold_cnt   <= hold_nxt;
      filt_cnt   <= filt_nxt;
      loss_count <= loss_nxt;
    end
  end

  // Next-state logic; loss of lock outranks the software reset request.
  always_comb begin
    state_nxt  = state;
    stable_nxt = stable_cnt;
    hold_nxt   = hold_cnt;
    filt_nxt   = '0;
    loss_nxt   = loss_count;
    case (state)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt  = STABLE;
          stable_nxt = '0;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
        end else if (stable_cnt == STABLE_LAST) begin
          state_nxt = HOLD;
          hold_nxt  = '0;
        end else begin
          stable_nxt = stable_cnt + STW'(1);
        end
      end
      HOLD: begin
        if (filt_expire) begin
          state_nxt = WAIT_LOCK;
        end else if (hold_cnt == HOLD_LAST) begin
          // Entering RUN starts the filter from zero.
          state_nxt = RUN;
        end else begin
          hold_nxt = hold_cnt + HLW'(1);
          filt_nxt = filt_step;
        end
      end
      RUN: begin
        if (filt_expire) begin
          state_nxt = WAIT_LOCK;
          loss_nxt  = sat_inc(loss_count);
        end else if (sw_rst) begin
          state_nxt = HOLD;
          hold_nxt  = '0;
        end else begin
          filt_nxt = filt_step;
        end
      end
      default: begin
        state_nxt = WAIT_LOCK;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs track state.
  always_comb begin
    rst_nxt   = (state_nxt != RUN);
    ready_nxt = (state_nxt == RUN);
  end

  // Dedicated output flops keep rst_out and ready glitch-free.
  always_ff @(posedge clock) begin
    if (reset) begin
      rst_out <= 1'b1;
      ready   <= 1'b0;
    end else begin
      rst_out <= rst_nxt;
      ready   <= ready_nxt;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short qualification times.
module tb_pll_reset_sequencer;

  localparam int CNT_W = 2;

  logic             clock = 1'b0;
  logic             reset;
  logic             pll_locked;
  logic             sw_rst;
  logic             rst_out;
  logic             ready;
  logic [CNT_W-1:0] loss_count;
  logic [1:0]       state_dbg;

  int n_cmp = 0;
  int n_bad = 0;

  pll_reset_sequencer #(
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(8),
    .HOLD_CYCLES  (4),
    .LOSS_FILTER  (3),
    .CNT_W        (CNT_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .pll_locked(pll_locked),
    .sw_rst    (sw_rst),
    .rst_out   (rst_out),
    .ready     (ready),
    .loss_count(loss_count),
    .state_dbg (state_dbg)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One active edge, then settle at the falling edge for sampling/driving.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1; pll_locked = 1'b0; sw_rst = 1'b0;
    step();
    chk({tag, "_state"}, int'(state_dbg), 0);
    chk({tag, "_rst"},   int'(rst_out), 1);
    chk({tag, "_ready"}, int'(ready), 0);
    chk({tag, "_loss"},  int'(loss_count), 0);
    reset = 1'b0;
  endtask

  // From WAIT_LOCK with a cleared synchroniser: lock raised before edge 0.
  // Expected: edges 0-1 WAIT_LOCK, 2-9 STABLE, 10-13 HOLD, 14 RUN.
  task automatic bringup(input string tag, input bit sw_hold);
    int es;
    for (int k = 0; k <= 14; k++) begin
      pll_locked = 1'b1;
      sw_rst = sw_hold && (k < 14);
      step();
      es = (k < 2) ? 0 : (k < 10) ? 1 : (k < 14) ? 2 : 3;
      chk($sformatf("%s_state_e%0d", tag, k), int'(state_dbg), es);
      if (k >= 13) begin
        chk($sformatf("%s_rst_e%0d", tag, k), int'(rst_out), (k < 14) ? 1 : 0);
        chk($sformatf("%s_ready_e%0d", tag, k), int'(ready), (k < 14) ? 0 : 1);
      end
    end
    sw_rst = 1'b0;
  endtask

  // From RUN: hold lock low; third synchronised low sample is at edge 4.
  task automatic lose(input string tag, input int exp_loss, input bit sw_at_exp);
    for (int k = 0; k <= 4; k++) begin
      pll_locked = 1'b0;
      sw_rst = sw_at_exp && (k == 4);
      step();
      if (k == 3) begin
        chk({tag, "_state_e3"}, int'(state_dbg), 3);
        chk({tag, "_rst_e3"}, int'(rst_out), 0);
      end
      if (k == 4) begin
        chk({tag, "_state_e4"}, int'(state_dbg), 0);
        chk({tag, "_rst_e4"}, int'(rst_out), 1);
        chk({tag, "_loss_e4"}, int'(loss_count), exp_loss);
      end
    end
    sw_rst = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pll_locked = 1'b0; sw_rst = 1'b0;
    @(negedge clock);
    step();
    do_reset("rst0");

    // Clean bring-up
    bringup("boot", 1'b0);
    chk("boot_loss", int'(loss_count), 0);

    // Two-cycle glitch in RUN is filtered out
    for (int k = 0; k <= 5; k++) begin
      pll_locked = !(k == 0 || k == 1);
      step();
      chk($sformatf("glitch_state_e%0d", k), int'(state_dbg), 3);
      chk($sformatf("glitch_rst_e%0d", k), int'(rst_out), 0);
    end
    chk("glitch_loss", int'(loss_count), 0);

    // Software reset in RUN: four cycles of HOLD, then RUN
    for (int k = 0; k <= 4; k++) begin
      sw_rst = (k == 0);
      step();
      chk($sformatf("swr_rst_e%0d", k), int'(rst_out), (k < 4) ? 1 : 0);
      chk($sformatf("swr_state_e%0d", k), int'(state_dbg), (k < 4) ? 2 : 3);
    end
    sw_rst = 1'b0;
    chk("swr_loss", int'(loss_count), 0);

    // Sustained losses, counter saturates at 3
    lose("loss1", 1, 1'b0); bringup("relock1", 1'b0);
    lose("loss2", 2, 1'b0); bringup("relock2", 1'b0);
    lose("loss3", 3, 1'b0); bringup("relock3", 1'b0);
    lose("loss4", 3, 1'b0); bringup("relock4", 1'b0);

    // Reset while running clears everything on the next edge
    reset = 1'b1;
    step();
    chk("runrst_state", int'(state_dbg), 0);
    chk("runrst_rst", int'(rst_out), 1);
    chk("runrst_ready", int'(ready), 0);
    chk("runrst_loss", int'(loss_count), 0);
    reset = 1'b0; pll_locked = 1'b0;

    // One-cycle lock drop at edge 6 during STABLE: RUN at edge 21
    for (int k = 0; k <= 21; k++) begin
      pll_locked = (k != 6);
      step();
      if (k == 7)  chk("stg_state_e7", int'(state_dbg), 1);
      if (k == 8)  chk("stg_state_e8", int'(state_dbg), 0);
      if (k == 9)  chk("stg_state_e9", int'(state_dbg), 1);
      if (k == 17) chk("stg_state_e17", int'(state_dbg), 2);
      if (k == 20) chk("stg_rst_e20", int'(rst_out), 1);
      if (k == 21) begin
        chk("stg_rst_e21", int'(rst_out), 0);
        chk("stg_ready_e21", int'(ready), 1);
        chk("stg_loss", int'(loss_count), 0);
      end
    end

    // sw_rst on the filter-expiry edge: loss wins
    lose("prio", 1, 1'b1);

    // sw_rst held through WAIT_LOCK, STABLE and HOLD has no effect
    do_reset("rst1");
    bringup("swign", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
